// File: rtl/dbg_log_arb.sv
// Packet-locked round-robin merge of N_IN log streams onto one tagged stream; 1-cycle arbitration bubble per packet.
// Registered output, 1 flit/cycle within a packet; in_TREADY of the granted input follows output-register free space.
`timescale 1ns/1ps
module dbg_log_arb #(
    parameter int LOG_WIDTH = 72,
    parameter int N_IN      = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_IN*LOG_WIDTH-1:0] in_TDATA,
    input  logic [N_IN-1:0]           in_TVALID,
    output logic [N_IN-1:0]           in_TREADY,
    input  logic [N_IN-1:0]           in_TLAST,
    output logic [LOG_WIDTH-1:0]      out_TDATA,
    output logic                      out_TVALID,
    input  logic                      out_TREADY,
    output logic                      out_TLAST,
    output logic [SEL_WIDTH-1:0]      out_TID
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state, state_nxt;
    logic [SEL_WIDTH-1:0] sel, sel_nxt, ptr, ptr_nxt;
    logic                 can_load, accept;
    logic                 g_vld, g_last;
    logic [LOG_WIDTH-1:0] g_data;
    logic                 any_req, hi_req;
    logic [SEL_WIDTH-1:0] first_any, first_hi, pick;

    assign can_load = !out_TVALID || out_TREADY;

    // Granted-input mux
    always_comb begin
        g_vld  = 1'b0;
        g_last = 1'b0;
        g_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                g_vld  = in_TVALID[i];
                g_last = in_TLAST[i];
                g_data = in_TDATA[i*LOG_WIDTH +: LOG_WIDTH];
            end
        end
    end

    // Round-robin scan: lowest requester at or above ptr, else lowest requester overall.
    always_comb begin
        any_req   = 1'b0;
        hi_req    = 1'b0;
        first_any = '0;
        first_hi  = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (in_TVALID[i]) begin
                any_req   = 1'b1;
                first_any = SEL_WIDTH'(i);
                if (SEL_WIDTH'(i) >= ptr) begin
                    hi_req   = 1'b1;
                    first_hi = SEL_WIDTH'(i);
                end
            end
        end
        pick = hi_req ? first_hi : first_any;
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        in_TREADY = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_nxt   = pick;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                for (int i = 0; i < N_IN; i++) begin
                    if (sel == SEL_WIDTH'(i)) in_TREADY[i] = can_load;
                end
                accept = g_vld && can_load;
                if (accept && g_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (int'(sel) == N_IN - 1) ? '0 : sel + SEL_WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel        <= '0;
            ptr        <= '0;
            out_TDATA  <= '0;
            out_TVALID <= 1'b0;
            out_TLAST  <= 1'b0;
            out_TID    <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            if (accept) begin
                out_TDATA  <= g_data;
                out_TLAST  <= g_last;
                out_TID    <= sel;
                out_TVALID <= 1'b1;
            end else if (out_TREADY) begin
                out_TVALID <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dbg_log_arb.md
Name: dbg_log_arb

Overview:
- Packet-aware round-robin arbiter merging the concatenated log streams of N_IN daisy-chained debug governors onto one output log stream.
- Holds its grant for a whole packet, from first flit to TLAST, so packets from different governors never interleave.
- Tags each output flit with the source index.
- Sits between the governors' log ports and the single log sink (DMA / UART bridge).

Parameters:
- LOG_WIDTH, 72, width of one log flit (DATA_WIDTH + DATA_WIDTH/8 for DATA_WIDTH=64).
- N_IN, 4, number of log inputs (1..16).
- SEL_WIDTH, 2, width of the source index; must satisfy 2**SEL_WIDTH >= N_IN, minimum 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_TDATA  in  N_IN*LOG_WIDTH  flattened input data; input i occupies bits [i*LOG_WIDTH +: LOG_WIDTH].
- in_TVALID  in  N_IN  per-input valid.
- in_TREADY  out  N_IN  per-input ready.
- in_TLAST  in  N_IN  per-input end of packet.
- out_TDATA  out  LOG_WIDTH  registered output data.
- out_TVALID  out  1  registered output valid.
- out_TREADY  in  1  output ready.
- out_TLAST  out  1  registered end of packet.
- out_TID  out  SEL_WIDTH  index of the input the flit came from.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_TVALID=0, out_TDATA=0, out_TLAST=0, out_TID=0, in_TREADY=0.
  - State=IDLE, priority pointer ptr=0.
  - Any packet in flight is abandoned; no flit is replayed after release.
- Output stage: a single register.
  - can_load = !out_TVALID || out_TREADY.
  - A flit is accepted from the granted input when in_TVALID[sel] && in_TREADY[sel].
  - An accepted flit appears on out_* the next cycle with out_TID=sel.
  - Output holds stable while out_TVALID && !out_TREADY (AXIS rule).
  - If no flit is accepted and out_TREADY=1, out_TVALID clears next cycle.
- State IDLE:
  - in_TREADY=0 on all inputs.
  - Selects the first i with in_TVALID[i]=1, scanning ptr, ptr+1, ... modulo N_IN.
  - If one is found: sel<=i, next state LOCKED. The decision takes one cycle; no flit transfers in IDLE.
  - If none is found: stay in IDLE.
- State LOCKED:
  - in_TREADY[sel]=can_load (combinational); all other in_TREADY bits = 0.
  - When a flit with in_TLAST[sel]=1 is accepted: next state IDLE, ptr<=(sel+1) mod N_IN.
  - Non-TLAST flits keep the grant indefinitely, with no timeout. A stalled granted input (TVALID=0) blocks all others.
- Timing and fairness:
  - There is a minimum 1-cycle bubble between packets, for the IDLE arbitration cycle.
  - Peak throughput: 1 flit/cycle within a packet.
  - Fairness: with all inputs continuously requesting, grants rotate 0,1,..,N_IN-1,0 packet by packet.
  - An input that deasserts TVALID while not granted loses nothing.
  - Inputs must hold TVALID, TDATA and TLAST stable until accepted (AXIS).
- Simultaneous events:
  - Within one cycle, out_TREADY=1 and a new accept is allowed (full throughput); the register reloads with the new flit.
  - TLAST accept plus a new request from the same input: the pointer has moved past it, so other requesters win first.
- Width and index rules:
  - ptr and sel are SEL_WIDTH bits and wrap at N_IN, not at 2**SEL_WIDTH.
  - Indices >= N_IN are never granted.
  - With N_IN=1 the block degenerates to a register stage with a 1-cycle bubble after each TLAST; out_TID is always 0.

Test Plan:
- Reset: hold rst=0 with all inputs valid -> out_TVALID=0 and in_TREADY=4'b0000 throughout; after release, the first grant goes to input 0 (ptr=0).
- Single packet:
  - Stimulus: input 2 sends 3 flits 0xA1,0xA2,0xA3 (TLAST on 0xA3) with out_TREADY=1.
  - Response: the out stream is 0xA1,0xA2,0xA3 on consecutive cycles, TID=2 each, TLAST only on 0xA3, starting 2 cycles after TVALID rises.
- Round robin:
  - Stimulus: all 4 inputs continuously offer 2-flit packets, with data = input index.
  - Response: out_TID sequence per packet is 0,1,2,3,0,...; no interleaving within a packet; exactly 1 idle cycle between packets.
- Backpressure:
  - Stimulus: out_TREADY toggles randomly (~25% low) during a 100-flit packet from input 1.
  - Response: all 100 flits arrive in order with none duplicated or dropped; out_TDATA stays stable while stalled; in_TREADY[1]=0 whenever out_TVALID && !out_TREADY.
- Lock hold:
  - Stimulus: input 3 is granted, then drops TVALID for 10 cycles mid-packet while input 0 requests.
  - Response: input 0 is not granted until input 3's TLAST is accepted; input 0 is granted next.
- Reset mid-packet:
  - Stimulus: assert rst=0 during flit 2 of 4 from input 1.
  - Response: out_TVALID drops immediately (asynchronous); after release, state=IDLE, ptr=0, and input 1's remaining flits are treated as a new packet.
